mem_stream_reader: RTL and testbench
====================================

# mem_stream_reader

Read-side streaming engine for the MLP controller: on a start command it reads `num_words` consecutive words from a `memory_block` read port and pushes them, in address order, into a downstream `fifo`. It hides the memory's fixed registered read latency with an internal skid buffer and stalls on downstream `full`. No word is lost or duplicated, and throughput is sustained at one word per cycle when unstalled. It is the consumer of the data that writers place in `memory_block`, and the producer for the `fifo` push side.

## Interface
- DATAW, 512, word width; matches the `memory_block` DATAW
- ADDRW, 9, memory address width
- CNTW, 10, width of the word-count field
- RD_LATENCY, 2, cycles from a read request (`mem_rd`/`mem_raddr`) to valid `mem_rdata`; 2 for `memory_block` with registered output
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- start  input  1  one-cycle command strobe; sampled only in IDLE
- base_addr  input  ADDRW  first address to read; sampled with `start`
- num_words  input  CNTW  number of words to read; sampled with `start`
- busy  output  1  high while a command is in progress
- done  output  1  one-cycle pulse when the last word has been accepted by the FIFO
- mem_rd  output  1  read request this cycle (registered)
- mem_raddr  output  ADDRW  read address (registered)
- mem_rdata  input  DATAW  read data, valid RD_LATENCY cycles after the `mem_rd` cycle
- fifo_push  output  DATAW-independent 1  push strobe to the downstream FIFO
- fifo_wdata  output  DATAW  push data: the head of the skid buffer
- fifo_full  input  1  downstream FIFO full; no push is accepted while it is high

## Operation
- Internal skid buffer: a circular buffer of SKID = RD_LATENCY+2 entries, with head/tail pointers and an occupancy counter.
- In-flight tracking: a RD_LATENCY-deep shift register of valid bits, fed by `mem_rd`. Its output marks the `mem_rdata` cycle.
- Count widths:
  - `inflight` = popcount of the shift register.
  - `occ` = skid occupancy.
  - `remaining` = reads not yet issued, CNTW bits.
  - `outstanding` = words not yet pushed, CNTW bits.
- States:
  - IDLE: `busy`=0. On `start`, latch `base_addr`, then:
    - `num_words`≠0: set `remaining`=`outstanding`=`num_words` and go to RUN.
    - `num_words`=0: go to FINISH.
- RUN:
  - Issue a read (next-cycle `mem_rd`=1, `mem_raddr`=current address) when `remaining`≠0 and `occ`+`inflight` < SKID.
  - On each issue, the address increments modulo 2^ADDRW (wraps from 2^ADDRW−1 to 0) and `remaining` decrements.
  - When the shift-register output is 1, write `mem_rdata` into the skid at tail.
  - `fifo_push` = (`occ`≠0) && !`fifo_full`. On push, advance head and decrement `outstanding`.
  - A write and a pop in the same cycle leave `occ` unchanged.
  - When a push makes `outstanding` reach 0, go to FINISH.
- FINISH: `done`=1 for exactly one cycle, then IDLE.
- `start` is ignored in RUN and FINISH; it is not queued.
- Ordering: words leave in strictly increasing, wrapped address order.
- Backpressure: `fifo_full` held high stops pushes only. Reads already issued still land, and the skid never overflows.
- Reset mid-operation: all state clears, in-flight data is discarded, and no `done` pulse is produced.
- Reset values: `busy`=0, `done`=0, `mem_rd`=0, `mem_raddr`=0, `fifo_push`=0, `fifo_wdata`=0.
  - `fifo_wdata` is don't-care whenever `fifo_push`=0 after reset.

## Timing
- `start` is sampled at cycle T.
- `busy`:
  - Rises at T+1 and stays high through the `done` cycle.
  - Falls the cycle after `done`.
- Reads: first `mem_rd` at T+1 with `mem_raddr`=`base_addr`.
- First data:
  - The first word lands in the skid at the end of cycle T+1+RD_LATENCY.
  - The first `fifo_push` is at T+2+RD_LATENCY, which is T+4 for the default RD_LATENCY.
- Unstalled command of N words:
  - Reads issue at T+1 … T+N.
  - Pushes occur at T+4 … T+N+3, back-to-back.
  - `done` at T+N+4.
- `num_words`=0: `done` at T+1, no `mem_rd` and no `fifo_push`. `busy` is high only at T+1.
- New command: the earliest accepted `start` is the cycle after `done`.
- Memory: `mem_rd`/`mem_raddr` drive the `memory_block` read port directly. The block never drives a write.

## Test plan
- Load mem[i]=i+100. Start with base=5, N=8, and `fifo_full`=0 throughout.
  - Response: pushes 105…112 on T+4…T+11 with no gaps.
  - `done` at T+12; `busy` high on T+1…T+12.
- Wrap-around: base=510, N=4, ADDRW=9.
  - Response: `mem_raddr` sequence 510, 511, 0, 1, and data pushed in that order.
- Backpressure: N=16, with `fifo_full` held high for cycles T+5…T+14.
  - No push occurs while `fifo_full` is high.
  - No more than SKID=4 words are buffered and `mem_rd` stalls accordingly.
  - All 16 words arrive in order, exactly once.
- Zero length: N=0.
  - `done` at T+1, with no `mem_rd` and no `fifo_push`.
- `start` pulsed at T+3 while busy with N=6 is ignored.
  - Exactly 6 pushes occur and exactly one `done`.
- `rst` asserted at T+5 with N=10 (reads in flight).
  - The next cycle shows all outputs at their reset values, with no further pushes and no `done`.
  - A new start with N=2 then completes normally.

Source files
------------

// File: rtl/mem_stream_reader.sv
// Streams num_words consecutive memory_block words into a downstream FIFO,
// hiding the registered read latency behind a small circular skid buffer.
module mem_stream_reader #(
   parameter int DATAW      = 512,
   parameter int ADDRW      = 9,
   parameter int CNTW       = 10,
   parameter int RD_LATENCY = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [ADDRW-1:0] base_addr,
   input  logic [CNTW-1:0]  num_words,
   output logic             busy,
   output logic             done,
   output logic             mem_rd,
   output logic [ADDRW-1:0] mem_raddr,
   input  logic [DATAW-1:0] mem_rdata,
   output logic             fifo_push,
   output logic [DATAW-1:0] fifo_wdata,
   input  logic             fifo_full
);

   localparam int SKID = RD_LATENCY + 2;
   localparam int PW   = (SKID > 1) ? $clog2(SKID) : 1;
   localparam int OW   = $clog2(SKID + 1);
   localparam int BW   = $clog2(2 * SKID + 2);
   localparam logic [BW-1:0] SKID_B   = BW'(SKID);
   localparam logic [PW-1:0] PTR_LAST = PW'(SKID - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t             state_r, state_s;
   logic [ADDRW-1:0]   addr_r, issue_addr_s;
   logic [CNTW-1:0]    remaining_r, outstanding_r;
   logic [RD_LATENCY-1:0] sr_r;
   logic [DATAW-1:0]   skid_r [SKID];
   logic [PW-1:0]      head_r, tail_r;
   logic [OW-1:0]      occ_r;
   logic               mem_rd_r;
   logic [ADDRW-1:0]   mem_raddr_r;
   logic               wr_s, pop_s, issue_s;
   logic [BW-1:0]      inflight_s, owed_s;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PTR_LAST) begin
         ptr_inc = {PW{1'b0}};
      end else begin
         ptr_inc = p + PW'(1);
      end
   endfunction

   // Popcount of read-valid shift register: reads whose data has not landed yet
   always_comb begin
      inflight_s = {BW{1'b0}};
      for (int i = 0; i < RD_LATENCY; i++) begin
         inflight_s = inflight_s + BW'(sr_r[i]);
      end
   end

   assign wr_s         = sr_r[RD_LATENCY-1];
   assign pop_s        = (occ_r != {OW{1'b0}}) && !fifo_full;
   // Words already owed to the skid, including the read on the port this cycle
   assign owed_s       = BW'(occ_r) + inflight_s + BW'(mem_rd_r) - BW'(pop_s);
   assign issue_addr_s = (state_r == IDLE) ? base_addr : addr_r;

   // Next-state and read-issue decision
   always_comb begin
      state_s = state_r;
      issue_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               issue_s = (num_words != {CNTW{1'b0}});
               state_s = issue_s ? RUN : FINISH;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            issue_s = (remaining_r != {CNTW{1'b0}}) && (owed_s < SKID_B);
            if (pop_s && (outstanding_r == CNTW'(1))) begin
               state_s = FINISH;
            end else begin
               state_s = RUN;
            end
         end
         FINISH:  state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Read issue, in-flight tracking, skid buffer and word counters
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_rd_r      <= 1'b0;
         mem_raddr_r   <= {ADDRW{1'b0}};
         addr_r        <= {ADDRW{1'b0}};
         remaining_r   <= {CNTW{1'b0}};
         outstanding_r <= {CNTW{1'b0}};
         sr_r          <= {RD_LATENCY{1'b0}};
         head_r        <= {PW{1'b0}};
         tail_r        <= {PW{1'b0}};
         occ_r         <= {OW{1'b0}};
         for (int i = 0; i < SKID; i++) begin
            skid_r[i] <= {DATAW{1'b0}};
         end
      end else begin
         mem_rd_r <= issue_s;
         sr_r[0]  <= mem_rd_r;
         for (int i = 1; i < RD_LATENCY; i++) begin
            sr_r[i] <= sr_r[i-1];
         end
         if (issue_s) begin
            mem_raddr_r <= issue_addr_s;
            addr_r      <= issue_addr_s + ADDRW'(1);
         end
         if ((state_r == IDLE) && start) begin
            remaining_r   <= num_words - CNTW'(issue_s);
            outstanding_r <= num_words;
         end else begin
            if (issue_s) begin
               remaining_r <= remaining_r - CNTW'(1);
            end
            if (pop_s) begin
               outstanding_r <= outstanding_r - CNTW'(1);
            end
         end
         if (wr_s) begin
            skid_r[tail_r] <= mem_rdata;
            tail_r         <= ptr_inc(tail_r);
         end
         if (pop_s) begin
            head_r <= ptr_inc(head_r);
         end
         occ_r <= occ_r + OW'(wr_s) - OW'(pop_s);
      end
   end

   assign busy       = (state_r != IDLE);
   assign done       = (state_r == FINISH);
   assign mem_rd     = mem_rd_r;
   assign mem_raddr  = mem_raddr_r;
   assign fifo_push  = pop_s;
   assign fifo_wdata = skid_r[head_r];

endmodule

// File: tb/tb_mem_stream_reader.sv
// Randomized self-checking bench: expected words/addresses come from the memory
// image and the command, expected timing from the command length.
module tb_mem_stream_reader;

   logic         clk = 1'b0;
   logic         rst, start, fifo_full;
   logic [8:0]   base_addr;
   logic [9:0]   num_words;
   logic         busy, done, mem_rd, fifo_push;
   logic [8:0]   mem_raddr;
   logic [511:0] mem_rdata, fifo_wdata, s1;
   logic [511:0] mem [0:511];
   int           total = 0;
   int           bad   = 0;

   mem_stream_reader dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
      .busy(busy), .done(done), .mem_rd(mem_rd), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
      .fifo_push(fifo_push), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full)
   );

   always #5 clk = ~clk;

   // memory_block with registered output: data two cycles after the read cycle
   always @(posedge clk) begin
      s1        <= mem[mem_raddr];
      mem_rdata <= s1;
   end

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // mode: 0 unstalled with exact timing, 1 full on k=5..14, 2 extra start at k=3,
   //       3 reset at k=5, 4 random fifo_full
   task automatic run_cmd(input logic [8:0] b, input int n, input int mode);
      logic [511:0] exp_data[$];
      logic [8:0]   exp_addr[$];
      int rd_cnt = 0, push_cnt = 0, done_cnt = 0, done_k = -1;
      int exp_done_k;
      bit strict, finished;
      strict     = (mode == 0) || (mode == 2);
      finished   = 1'b0;
      exp_done_k = (n == 0) ? 1 : n + 4;
      for (int i = 0; i < n; i++) begin
         exp_addr.push_back(9'((int'(b) + i) % 512));
         exp_data.push_back(mem[(int'(b) + i) % 512]);
      end
      @(posedge clk); #1;
      start = 1'b1; base_addr = b; num_words = 10'(n); fifo_full = 1'b0;
      @(negedge clk);
      chk("busy_at_T", 512'(busy), 512'(0));
      for (int k = 1; k <= 400 && !finished; k++) begin
         @(posedge clk); #1;
         start = (mode == 2) && (k == 3);
         if (start) base_addr = b ^ 9'h0ff;
         rst = (mode == 3) && (k == 5);
         if (mode == 1)      fifo_full = (k >= 5) && (k <= 14);
         else if (mode == 4) fifo_full = 1'($urandom_range(0, 1));
         else                fifo_full = 1'b0;
         @(negedge clk);
         if (mode == 3 && k == 6) begin
            chk("rst_busy", 512'(busy), 512'(0));
            chk("rst_done", 512'(done), 512'(0));
            chk("rst_mem_rd", 512'(mem_rd), 512'(0));
            chk("rst_raddr", 512'(mem_raddr), 512'(0));
            chk("rst_push", 512'(fifo_push), 512'(0));
            chk("rst_wdata", fifo_wdata, 512'(0));
            for (int j = 0; j < 20; j++) begin
               @(negedge clk);
               chk("post_rst_push", 512'(fifo_push), 512'(0));
               chk("post_rst_done", 512'(done), 512'(0));
               chk("post_rst_rd", 512'(mem_rd), 512'(0));
            end
            finished = 1'b1;
         end else begin
            if (mem_rd) begin
               chk("rd_in_range", 512'(rd_cnt < n), 512'(1));
               if (rd_cnt < n) chk("raddr", 512'(mem_raddr), 512'(exp_addr[rd_cnt]));
               rd_cnt++;
            end
            chk("skid_bound", 512'((rd_cnt - push_cnt) <= 4), 512'(1));
            if (fifo_push) begin
               chk("push_while_full", 512'(fifo_full), 512'(0));
               chk("push_in_range", 512'(push_cnt < n), 512'(1));
               if (push_cnt < n) chk("wdata", fifo_wdata, exp_data[push_cnt]);
               push_cnt++;
            end
            if (strict) begin
               chk("rd_timing", 512'(mem_rd), 512'(k <= n));
               chk("push_timing", 512'(fifo_push), 512'(k >= 4 && k <= n + 3));
               chk("done_timing", 512'(done), 512'(k == exp_done_k));
            end
            if (done_k < 0) begin
               chk("busy_high", 512'(busy), 512'(1));
            end else begin
               chk("busy_low_after_done", 512'(busy), 512'(0));
               chk("done_one_cycle", 512'(done), 512'(0));
               finished = 1'b1;
            end
            if (done) begin
               done_cnt++;
               if (done_k < 0) done_k = k;
            end
         end
      end
      if (mode != 3) begin
         chk("no_timeout", 512'(finished), 512'(1));
         chk("n_reads", 512'(rd_cnt), 512'(n));
         chk("n_pushes", 512'(push_cnt), 512'(n));
         chk("n_done", 512'(done_cnt), 512'(1));
      end
      start = 1'b0; fifo_full = 1'b0; rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; fifo_full = 1'b0; base_addr = 9'd0; num_words = 10'd0;
      for (int i = 0; i < 512; i++) mem[i] = 512'(i + 100);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", 512'(busy), 512'(0));
      chk("reset_done", 512'(done), 512'(0));
      chk("reset_mem_rd", 512'(mem_rd), 512'(0));
      chk("reset_raddr", 512'(mem_raddr), 512'(0));
      chk("reset_push", 512'(fifo_push), 512'(0));
      chk("reset_wdata", fifo_wdata, 512'(0));
      @(posedge clk); #1;
      rst = 1'b0;

      run_cmd(9'd5, 8, 0);
      run_cmd(9'd510, 4, 0);
      run_cmd(9'd20, 16, 1);
      run_cmd(9'd7, 0, 0);
      run_cmd(9'd30, 6, 2);
      run_cmd(9'd40, 10, 3);
      run_cmd(9'd50, 2, 0);

      for (int i = 0; i < 512; i++)
         for (int w = 0; w < 16; w++) mem[i][w*32 +: 32] = $urandom;
      for (int t = 0; t < 8; t++)
         run_cmd(9'($urandom_range(0, 511)), int'($urandom_range(1, 40)), 4);
      for (int t = 0; t < 4; t++)
         run_cmd(9'($urandom_range(480, 511)), int'($urandom_range(1, 40)), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
